// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the multi-lane synchronous FIFO: acceptance clamps,
// wrap-aware pointer arithmetic and lane slicing of packed lane buses.
package sync_fifo_pkg;

  // Smaller of two non-negative quantities; used for every acceptance clamp.
  function automatic int sat_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Advance a pointer that carries one extra wrap bit above the slot index.
  function automatic int ptr_inc(input int ptr, input int n, input int depth);
    return (ptr + n) % (2 * depth);
  endfunction

  // Low bit position of a lane inside a packed multi-lane bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/sync_fifo_mp_if.sv
// Write, read and status bundle of the multi-lane FIFO. The master side
// offers/requests entries; the slave side is the FIFO itself.
interface sync_fifo_mp_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int NW    = 2,
  parameter int NR    = 2
);
  localparam int PW  = $clog2(DEPTH) + 1;
  localparam int WNW = $clog2(NW) + 1;
  localparam int WNR = $clog2(NR) + 1;

  logic                flush;
  logic [WNW-1:0]      w_num;
  logic [NW*WIDTH-1:0] din;
  logic [WNW-1:0]      w_acc;
  logic                w_fail;
  logic [WNR-1:0]      r_num;
  logic [NR*WIDTH-1:0] dout;
  logic [NR-1:0]       dout_valid;
  logic [WNR-1:0]      r_acc;
  logic                r_fail;
  logic [PW-1:0]       count;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [PW-1:0]       w_ptr;
  logic [PW-1:0]       r_ptr;

  modport master (
    output flush, w_num, din, r_num,
    input  w_acc, w_fail, dout, dout_valid, r_acc, r_fail, count,
           full, empty, almost_full, almost_empty, w_ptr, r_ptr
  );

  modport slave (
    input  flush, w_num, din, r_num,
    output w_acc, w_fail, dout, dout_valid, r_acc, r_fail, count,
           full, empty, almost_full, almost_empty, w_ptr, r_ptr
  );
endinterface

// File: rtl/sync_fifo_mp.sv
// Multi-lane synchronous FIFO: up to NW writes and NR reads per clock,
// first-word-fall-through read lanes, registered occupancy and status flags.
module sync_fifo_mp
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int NW        = 2,
  parameter int NR        = 2,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic           clk,
  input logic           reset_n,
  sync_fifo_mp_if.slave bus
);
  localparam int PW  = $clog2(DEPTH) + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int WNW = $clog2(NW) + 1;
  localparam int WNR = $clog2(NR) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    w_ptr_q, r_ptr_q, count_q;
  logic [PW-1:0]    w_ptr_nxt, r_ptr_nxt;
  logic [AW-1:0]    wr_slot [NW];
  logic [AW-1:0]    rd_slot [NR];
  int               w_req, r_req, free, w_cnt, r_cnt;

  // Acceptance counts come from start-of-cycle occupancy only, so reads never
  // free space for same-cycle writes and fresh writes are never readable.
  always_comb begin
    w_req = sat_min(int'(bus.w_num), NW);
    r_req = sat_min(int'(bus.r_num), NR);
    free  = DEPTH - int'(count_q);
    w_cnt = reset_n ? sat_min(w_req, free) : 0;
    r_cnt = reset_n ? sat_min(r_req, int'(count_q)) : 0;
    w_ptr_nxt = PW'(ptr_inc(int'(w_ptr_q), w_cnt, DEPTH));
    r_ptr_nxt = PW'(ptr_inc(int'(r_ptr_q), r_cnt, DEPTH));
    bus.w_acc  = WNW'(w_cnt);
    bus.r_acc  = WNR'(r_cnt);
    bus.w_fail = (w_req > free);
    bus.r_fail = (r_req > int'(count_q));
  end

  // Slot addresses for each lane; the dropped wrap bit gives modulo DEPTH.
  always_comb begin
    for (int k = 0; k < NW; k++) wr_slot[k] = AW'(int'(w_ptr_q) + k);
    for (int k = 0; k < NR; k++) rd_slot[k] = AW'(int'(r_ptr_q) + k);
  end

  // Head entries fall through onto the read lanes with no latency.
  always_comb begin
    bus.dout       = '0;
    bus.dout_valid = '0;
    for (int k = 0; k < NR; k++) begin
      bus.dout[lane_lo(k, WIDTH) +: WIDTH] = mem[rd_slot[k]];
      bus.dout_valid[k]                    = (int'(count_q) > k);
    end
  end

  // Storage: the lowest accepted lanes land in consecutive slots; never reset.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      for (int k = 0; k < NW; k++) begin
        if (k < w_cnt) mem[wr_slot[k]] <= bus.din[lane_lo(k, WIDTH) +: WIDTH];
      end
    end
  end

  // Pointer and occupancy registers; flush discards everything this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_nxt;
      r_ptr_q <= r_ptr_nxt;
      count_q <= count_q + PW'(w_cnt) - PW'(r_cnt);
    end
  end

  // Status flags depend on registered state only.
  always_comb begin
    bus.count        = count_q;
    bus.w_ptr        = w_ptr_q;
    bus.r_ptr        = r_ptr_q;
    bus.empty        = (w_ptr_q == r_ptr_q);
    bus.full         = (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]) &&
                       (w_ptr_q[AW] != r_ptr_q[AW]);
    bus.almost_full  = (int'(count_q) >= AF_THRESH);
    bus.almost_empty = (int'(count_q) <= AE_THRESH);
  end

endmodule

// File: tb/tb_sync_fifo_mp.sv
// Directed bench for sync_fifo_mp with a reference occupancy model and a
// data scoreboard queue.
module tb_sync_fifo_mp;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int NW    = 2;
  localparam int NR    = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_mp_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NW(NW), .NR(NR)) bus ();

  sync_fifo_mp #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NW(NW), .NR(NR),
    .AF_THRESH(6), .AE_THRESH(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int vecs = 0;
  int miscompares = 0;
  int m_count = 0;
  int m_wptr = 0;
  int m_rptr = 0;
  logic [7:0] sb [$];
  logic seen_msb0, seen_msb1;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_wptr  = 0;
    m_rptr  = 0;
    sb.delete();
  endtask

  task automatic check_state();
    chk("count", bus.count, m_count);
    chk("empty", bus.empty, m_count == 0);
    chk("full", bus.full, m_count == DEPTH);
    chk("almost_full", bus.almost_full, m_count >= 6);
    chk("almost_empty", bus.almost_empty, m_count <= 2);
    chk("dout_valid", bus.dout_valid, {m_count > 1, m_count > 0});
    chk("w_ptr", bus.w_ptr, m_wptr);
    chk("r_ptr", bus.r_ptr, m_rptr);
    for (int k = 0; k < NR; k++)
      if (k < m_count) chk($sformatf("dout%0d", k), bus.dout[k*WIDTH +: WIDTH], sb[k]);
  endtask

  // One clock: drive after the edge, check on the falling edge, then update the model.
  task automatic cycle(input int wn, input int rn, input logic fl, input int d0, input int d1);
    int ew, er, wq, rq;
    bus.w_num = 2'(wn);
    bus.r_num = 2'(rn);
    bus.flush = fl;
    bus.din   = {8'(d1), 8'(d0)};
    @(negedge clk);
    wq = imin(wn, NW);
    rq = imin(rn, NR);
    ew = imin(wq, DEPTH - m_count);
    er = imin(rq, m_count);
    check_state();
    chk("w_acc", bus.w_acc, ew);
    chk("w_fail", bus.w_fail, wq > DEPTH - m_count);
    chk("r_acc", bus.r_acc, er);
    chk("r_fail", bus.r_fail, rq > m_count);
    if (bus.w_ptr[3]) seen_msb1 = 1'b1; else seen_msb0 = 1'b1;
    if (fl) begin
      model_reset();
    end else begin
      for (int k = 0; k < er; k++) void'(sb.pop_front());
      for (int k = 0; k < ew; k++) sb.push_back(k == 0 ? 8'(d0) : 8'(d1));
      m_count = m_count + ew - er;
      m_wptr  = (m_wptr + ew) % (2 * DEPTH);
      m_rptr  = (m_rptr + er) % (2 * DEPTH);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.w_num = 2'd2;
    bus.r_num = 2'd0;
    bus.din   = {8'hAA, 8'h55};

    // Reset asserted asynchronously with a write offered
    #1 reset_n = 1'b0;
    #2;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_almost_empty", bus.almost_empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_almost_full", bus.almost_full, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_w_acc", bus.w_acc, 0);
    @(posedge clk);
    #1;
    chk("rst_no_write", bus.count, 0);
    chk("rst_w_ptr", bus.w_ptr, 0);
    reset_n = 1'b1;
    model_reset();

    // Mid-operation asynchronous reset
    cycle(2, 0, 0, 8'h11, 8'h12);
    bus.w_num = 2'd2;
    bus.r_num = 2'd1;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_empty", bus.empty, 1);
    chk("mid_rst_dout_valid", bus.dout_valid, 0);
    chk("mid_rst_w_acc", bus.w_acc, 0);
    chk("mid_rst_r_acc", bus.r_acc, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("mid_rst_no_write", bus.count, 0);
    reset_n = 1'b1;

    // Burst fill: fifth offer finds the FIFO full
    for (int i = 0; i <= 8; i += 2) cycle(2, 0, 0, i, i + 1);
    // FWFT drain, then a read on empty
    for (int i = 0; i < 4; i++) cycle(0, 2, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Partial accept at count 7
    for (int i = 0; i < 3; i++) cycle(2, 0, 0, 30 + 2*i, 31 + 2*i);
    cycle(1, 0, 0, 36, 0);
    cycle(2, 0, 0, 20, 21);
    for (int i = 0; i < 4; i++) cycle(0, 2, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Wrap with concurrent reads and writes at count 3
    cycle(2, 0, 0, 70, 71);
    cycle(1, 0, 0, 72, 0);
    seen_msb0 = 1'b0;
    seen_msb1 = 1'b0;
    for (int i = 0; i < 10; i++) cycle(2, 2, 0, 80 + 2*i, 81 + 2*i);
    chk("w_ptr_msb_toggled", {seen_msb0, seen_msb1}, 2'b11);

    // Flush at count 5 with writes and reads offered
    cycle(2, 0, 0, 110, 111);
    cycle(2, 1, 1, 120, 121);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 50, 0);
    cycle(0, 1, 0, 0, 0);

    // Out-of-range lane counts clamp to NW/NR
    cycle(3, 0, 0, 60, 61);
    cycle(0, 3, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
